// File: rtl/hazard_fwd_scoreboard.sv
// Scoreboard-driven decode stall, EXE operand forwarding selects and stall-cycle counter.
// Build option: define HFS_FORWARD_EN to enable forwarding; otherwise dependents stall until WB.
module hazard_fwd_scoreboard #(
  parameter int  NSRC       = 2,
  parameter int  RW         = 4,
  parameter int  DEPTH      = 3,
  parameter int  LOAD_READY = 2,
  parameter int  CW         = 16,
  localparam int SW         = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NSRC*RW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_use,
  input  logic [RW-1:0]        id_dest,
  input  logic                 id_wb_en,
  input  logic                 id_mem_r_en,
  input  logic                 flush,
  output logic                 stall,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic [CW-1:0]        stall_cnt
);

  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [DEPTH-1:0]   wb_q, wb_d;
  logic [DEPTH-1:0]   ld_q, ld_d;
  logic [RW-1:0]      dest_q [DEPTH];
  logic [RW-1:0]      dest_d [DEPTH];
  logic [NSRC*RW-1:0] src_q  [DEPTH];
  logic [NSRC*RW-1:0] src_d  [DEPTH];
  logic [NSRC-1:0]    use_q  [DEPTH];
  logic [NSRC-1:0]    use_d  [DEPTH];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hazard;
  logic               issue;

  // Decode-stage hazard scan against every tracked producer
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (id_src_use[s] && vld_q[k] && wb_q[k] && (dest_q[k] == id_src[s*RW +: RW])) begin
`ifdef HFS_FORWARD_EN
          if (ld_q[k] && (k + 1 < LOAD_READY)) hazard = 1'b1;
`else
          if (k <= DEPTH - 2) hazard = 1'b1;
`endif
        end
      end
    end
  end

  assign stall = id_valid && !flush && hazard;
  assign issue = id_valid && !stall && !flush;

`ifdef HFS_FORWARD_EN
  // Scan oldest to youngest so the youngest eligible producer overwrites the select
  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (vld_q[0] && use_q[0][s] && vld_q[k] && wb_q[k] &&
            (dest_q[k] == src_q[0][s*RW +: RW]) && !(ld_q[k] && (k < LOAD_READY))) begin
          fwd_sel[s*SW +: SW] = SW'(k);
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign fwd_sel    = '0;
  assign unused_fwd = ^{src_q[0], use_q[0], ld_q, (LOAD_READY > 0)};
`endif

  always_comb begin
    vld_d     = {vld_q[DEPTH-2:0], issue};
    wb_d      = {wb_q[DEPTH-2:0], id_wb_en};
    ld_d      = {ld_q[DEPTH-2:0], id_mem_r_en};
    dest_d[0] = id_dest;
    src_d[0]  = id_src;
    use_d[0]  = id_src_use;
    for (int k = 1; k < DEPTH; k++) begin
      dest_d[k] = dest_q[k-1];
      src_d[k]  = src_q[k-1];
      use_d[k]  = use_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload fields are only meaningful under vld_q, so they carry no reset
  always_ff @(posedge clk) begin
    wb_q <= wb_d;
    ld_q <= ld_d;
    for (int k = 0; k < DEPTH; k++) begin
      dest_q[k] <= dest_d[k];
      src_q[k]  <= src_d[k];
      use_q[k]  <= use_d[k];
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed bench for hazard_fwd_scoreboard (DEPTH=3, LOAD_READY=2, CW=4) with a per-cycle model.
// Expectations follow HFS_FORWARD_EN, so the bench works for either build.
module tb_hazard_fwd_scoreboard;

`ifdef HFS_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [7:0] id_src = '0;
  logic [1:0] id_src_use = '0;
  logic [3:0] id_dest = '0;
  logic       id_wb_en = 1'b0;
  logic       id_mem_r_en = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic [3:0] fwd_sel;
  logic [3:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_fwd_scoreboard #(.NSRC(2), .RW(4), .DEPTH(3), .LOAD_READY(2), .CW(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the in-flight instructions, youngest first (index = pipeline stage)
  typedef struct packed {
    logic       v;
    logic       wb;
    logic       ld;
    logic [3:0] dest;
    logic [7:0] src;
    logic [1:0] rd;
  } ent_t;

  ent_t inflight [3];
  int   mcnt;

  function automatic bit produces(int k, logic [3:0] r);
    return inflight[k].v && inflight[k].wb && (inflight[k].dest == r);
  endfunction

  function automatic bit m_stall();
    logic [3:0] r;
    if (!id_valid || flush) return 1'b0;
    for (int s = 0; s < 2; s++) begin
      r = id_src[s*4 +: 4];
      if (id_src_use[s]) begin
        for (int k = 0; k < 3; k++) begin
          if (produces(k, r)) begin
            if (FWD && inflight[k].ld && (k + 1 < 2)) return 1'b1;
            if (!FWD && (k <= 1)) return 1'b1;
          end
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic int m_fwd(int s);
    logic [3:0] r;
    if (!FWD || !inflight[0].v || !inflight[0].rd[s]) return 0;
    r = inflight[0].src[s*4 +: 4];
    for (int k = 1; k < 3; k++)
      if (produces(k, r) && !(inflight[k].ld && (k < 2))) return k;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) inflight[k] <= '0;
      mcnt <= 0;
    end else begin
      if (m_stall() && (mcnt < CNT_MAX)) mcnt <= mcnt + 1;
      inflight[2] <= inflight[1];
      inflight[1] <= inflight[0];
      inflight[0] <= (id_valid && !m_stall() && !flush) ?
                     ent_t'{1'b1, id_wb_en, id_mem_r_en, id_dest, id_src, id_src_use} : '0;
    end
  end

  always @(negedge clk) begin
    chk("model_stall", int'(stall), int'(m_stall()));
    chk("model_fwd0", int'(fwd_sel[1:0]), m_fwd(0));
    chk("model_fwd1", int'(fwd_sel[3:2]), m_fwd(1));
    chk("model_cnt", int'(stall_cnt), mcnt);
  end

  // Drive one decode slot after the edge, return just after the following falling edge
  task automatic issue(input bit v, input int s0, input int s1, input bit [1:0] u,
                       input int d, input bit wb, input bit ld, input bit fl);
    @(posedge clk); #1;
    id_valid = v; id_src = {4'(s1), 4'(s0)}; id_src_use = u;
    id_dest = 4'(d); id_wb_en = wb; id_mem_r_en = ld; flush = fl;
    @(negedge clk); #1;
  endtask

  task automatic send(input bit v, input int s0, input int s1, input bit [1:0] u,
                      input int d, input bit wb, input bit ld, output int nst);
    issue(v, s0, s1, u, d, wb, ld, 1'b0);
    nst = 0;
    while (stall === 1'b1 && nst < 8) begin
      nst++;
      @(posedge clk); #1;
      @(negedge clk); #1;
    end
    if (stall === 1'b1) chk("stall_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst;
    // Reset held with random decode traffic
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      id_valid = 1'($urandom); id_src = 8'($urandom); id_src_use = 2'($urandom);
      id_dest = 4'($urandom); id_wb_en = 1'($urandom); id_mem_r_en = 1'($urandom);
      flush = 1'($urandom);
      @(negedge clk); #1;
      chk("rst_stall", int'(stall), 0);
    end
    chk("rst_fwd", int'(fwd_sel), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    @(posedge clk); #1;
    id_valid = 0; id_src = '0; id_src_use = '0; id_dest = '0;
    id_wb_en = 0; id_mem_r_en = 0; flush = 0;
    rst = 1'b1;

    // ADD r1 <- r7,r8 then SUB r4 <- r1,r2
    send(1, 7, 8, 2'b11, 1, 1, 0, nst);
    chk("first_issue_nst", nst, 0);
    send(1, 1, 2, 2'b11, 4, 1, 0, nst);
    chk("exe_exe_nst", nst, FWD ? 0 : 2);
    idle(1);
    chk("exe_exe_fwd", int'(fwd_sel), FWD ? 1 : 0);
    idle(3);

    // ADD r1; MOV r9 <- r10; SUB r4 <- r1,r2
    send(1, 7, 8, 2'b11, 1, 1, 0, nst);
    send(1, 10, 0, 2'b01, 9, 1, 0, nst);
    send(1, 1, 2, 2'b11, 4, 1, 0, nst);
    chk("gap_nst", nst, FWD ? 0 : 1);
    idle(1);
    chk("gap_fwd", int'(fwd_sel), FWD ? 2 : 0);
    idle(3);

    // LDR r2 <- [r11] then ADD r5 <- r2,r3
    send(1, 11, 0, 2'b01, 2, 1, 1, nst);
    send(1, 2, 3, 2'b11, 5, 1, 0, nst);
    chk("load_use_nst", nst, FWD ? 1 : 2);
    idle(1);
    chk("load_use_fwd", int'(fwd_sel), FWD ? 2 : 0);
    chk("load_use_cnt", int'(stall_cnt), FWD ? 1 : 5);
    idle(3);

    // MOV r3; ADD r3; ORR r6 <- r3,r3
    send(1, 12, 0, 2'b01, 3, 1, 0, nst);
    send(1, 13, 14, 2'b11, 3, 1, 0, nst);
    send(1, 3, 3, 2'b11, 6, 1, 0, nst);
    chk("youngest_nst", nst, FWD ? 0 : 2);
    idle(1);
    chk("youngest_fwd", int'(fwd_sel), FWD ? 5 : 0);
    chk("youngest_cnt", int'(stall_cnt), FWD ? 1 : 7);
    idle(3);

    // Flush on the dependent of a load
    send(1, 11, 0, 2'b01, 2, 1, 1, nst);
    issue(1, 2, 3, 2'b11, 5, 1, 0, 1);
    chk("flush_stall", int'(stall), 0);
    idle(1);
    chk("flush_fwd", int'(fwd_sel), 0);
    chk("flush_cnt", int'(stall_cnt), FWD ? 1 : 7);
    idle(3);

    // Unused operands never stall or forward
    send(1, 11, 0, 2'b01, 2, 1, 1, nst);
    issue(1, 2, 2, 2'b00, 5, 1, 0, 0);
    chk("nouse_stall", int'(stall), 0);
    idle(1);
    chk("nouse_fwd", int'(fwd_sel), 0);
    idle(3);

    // Repeated load-use pairs drive the counter into saturation
    for (int i = 0; i < 16; i++) begin
      send(1, 11, 0, 2'b01, 2, 1, 1, nst);
      send(1, 2, 3, 2'b11, 5, 1, 0, nst);
    end
    idle(1);
    chk("sat_cnt", int'(stall_cnt), CNT_MAX);
    idle(3);

    // Asynchronous reset in the middle of a stall
    send(1, 11, 0, 2'b01, 2, 1, 1, nst);
    issue(1, 2, 3, 2'b11, 5, 1, 0, 0);
    chk("midrst_pre_stall", int'(stall), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_fwd", int'(fwd_sel), 0);
    chk("midrst_cnt", int'(stall_cnt), 0);
    @(posedge clk); #1;
    id_valid = 0; id_src_use = '0;
    rst = 1'b1;
    issue(1, 2, 3, 2'b11, 5, 1, 0, 0);
    chk("post_rst_stall", int'(stall), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_scoreboard.md
# hazard_fwd_scoreboard

Parametrised hazard-detection and forwarding controller for the ARM pipeline. It replaces the separate fixed two-stage hazard and forwarding units. Issued instructions are tracked in an internal scoreboard shift register covering DEPTH stages from EXE to WB. The block produces:
- a decode stall,
- per-operand forwarding selects for the EXE-stage operand muxes,
- a stall-cycle counter.

## Interface
Parameters:
- NSRC, 2 — source operands per instruction
- RW, 4 — register address width
- DEPTH, 3 — tracked stages; index 0 = EXE, DEPTH-1 = WB; legal range ≥2
- LOAD_READY, 2 — first stage index at which load data is forwardable; legal range 1..DEPTH-1
- CW, 16 — stall counter width
- SW — derived, max(1, $clog2(DEPTH)); select width

Ports:
- clk  in  1  — clock; one clock domain, all state on rising edge
- rst  in  1  — asynchronous, active-low reset
- id_valid  in  1  — decode stage holds a real instruction
- id_src  in  NSRC*RW  — source register addresses; operand s is bits [s*RW +: RW]
- id_src_use  in  NSRC  — operand s is actually read
- id_dest  in  RW  — destination register
- id_wb_en  in  1  — instruction writes back
- id_mem_r_en  in  1  — instruction is a load
- flush  in  1  — branch taken; kills the decode instruction
- stall  out  1  — freeze PC, IF/ID, and insert a bubble
- fwd_sel  out  NSRC*SW  — per EXE operand: 0 = register-file value, k = result held at stage k
- stall_cnt  out  CW  — saturating count of stall cycles

## Operation
- Scoreboard entry fields: valid, wb, ld, dest, src[NSRC], use[NSRC]. Entries exist for stages 0..DEPTH-1.
- Each clock edge:
  - Entry k moves to k+1; entry DEPTH-1 is discarded.
  - Stage 0 loads the decode fields when id_valid && !stall && !flush. Otherwise stage 0 loads a bubble (valid=0).
- Producer at stage k matches source address a when: valid && wb && dest==a.
- Forwarding is combinational from registered state. For each operand s of stage 0 with valid && use[s]:
  - fwd_sel[s] = smallest k in 1..DEPTH-1 whose producer matches src[s] and is not (ld && k<LOAD_READY).
  - If no such k, fwd_sel[s] = 0.
  - The youngest match wins.
- Stall is combinational. stall=1 when id_valid && !flush and some operand s with id_src_use[s] matches a producer at stage k with ld && k+1<LOAD_READY.
- flush overrides stall: stall=0.
- stall_cnt increments on every clock edge where stall=1, and saturates at all ones.
- The scoreboard is not frozen by stall; bubbles advance normally.

## Timing
- Reset values: all entries invalid, stall=0, fwd_sel=0, stall_cnt=0. Reset is asserted asynchronously and released synchronously to clk by the integrating top.
- Latency:
  - fwd_sel reflects the instruction issued on the previous edge, with no further delay.
  - stall has the same-cycle combinational path from id_* inputs.
- Load-use, default parameters: exactly one stall cycle, then fwd_sel=2.
- Simultaneous stall and flush: no stall, a bubble enters, and stall_cnt does not increment.
- id_src_use[s]=0 never causes a stall or a forward for operand s.
- Reset asserted mid-stall: stall drops immediately (asynchronous); all in-flight entries are lost.

## Configuration
- HFS_FORWARD_EN defined:
  - Forwarding and stall behave as described above.
- HFS_FORWARD_EN undefined:
  - fwd_sel is tied to 0.
  - stall=1 whenever a used decode operand matches any producer at stage k ≤ DEPTH-2, regardless of ld.
  - The WB stage is not checked; the register file writes before it reads.
  - Scoreboard and counter behaviour is unchanged.

## Test plan
All scenarios use DEPTH=3, LOAD_READY=2.
- Reset: hold rst=0 with random inputs → stall=0, fwd_sel=0, stall_cnt=0. Release → first id_valid instruction issues with no stall.
- EXE→EXE: ADD r1 then SUB r4,r1,r2 → stall=0; next cycle fwd_sel[0]=1, fwd_sel[1]=0. With one independent instruction in between → fwd_sel[0]=2.
- Load-use: LDR r2 then ADD r5,r2,r3 → stall=1 for one cycle, stall_cnt=1; bubble enters stage 0, then ADD issues with fwd_sel[0]=2.
- Youngest wins: MOV r3 then ADD r3 then ORR r6,r3,r3 → fwd_sel[0]=fwd_sel[1]=1.
- Flush during load-use: LDR r2, then ADD using r2 with flush=1 → stall=0, stall_cnt unchanged; next cycle stage 0 invalid, fwd_sel=0.
- HFS_FORWARD_EN undefined: ADD r1 then SUB using r1 → stall=1 for two cycles, stall_cnt=2; fwd_sel stays 0.
